riscv_mc_controller: RTL and testbench
======================================

Name: riscv_mc_controller

Overview:
- Multicycle control unit that drives the 32-bit ALU (`alu_cntrl` encoding) and the multicycle datapath muxes and strobes.
- Fully decodes lw, sw, R-type add/sub/and/or, I-type addi/andi/ori, beq and jal, then sequences them through a Moore FSM.
- Waits on a memory ready handshake; traps on illegal encodings.
- Consumes the ALU `zero` flag to resolve branches.

Parameters:
- `MEM_WAIT_MAX`, default 255: maximum cycles spent in one memory state waiting for `mem_ready` before entering TRAP; 0 disables the timeout.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `op`  in  7  instr[6:0], from the instruction register
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `zero`  in  1  ALU zero flag, valid in the current cycle
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_write`  out  1  PC register enable
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction register / OldPC enable
- `result_src`  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALU result
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = 4
- `reg_write`  out  1  register file write enable
- `imm_src`  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J
- `alu_cntrl`  out  3  ALU operation: ADD = 000, SUB = 001, AND = 100, OR = 110
- `illegal_instr`  out  1  high while in TRAP
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- Clocking and reset:
  - Single clock `clk`; `reset` is synchronous and active-high.
  - While `reset` is high: state is forced to FETCH, all strobes (`pc_write`, `ir_write`, `mem_write`, `reg_write`), `instr_done` and `illegal_instr` are 0, and all selects are 0.
  - Reset wins over any transition, including TRAP and mid-wait states.
- Output timing: outputs are Moore outputs of the state, except `pc_write`, `ir_write` and the branch decision.
- `imm_src`: combinational from `op` in every state (lw/I-type 00, sw 01, beq 10, jal 11, otherwise 00).
- ALU decode:
  - Internal `alu_op` is 00 for ADD, 01 for SUB, 10 to decode by `funct3`.
  - 000 gives SUB if `op[5]` and `funct7b5` are both set, else ADD.
  - 110 gives OR; 111 gives AND.
- Legal set, checked in DECODE; any other combination goes to TRAP:
  - lw / sw: `funct3` = 010.
  - R-type: `funct3` in {000, 110, 111}; `funct7b5` = 1 only with 000.
  - I-type: `funct3` in {000, 110, 111}.
  - beq: `funct3` = 000.
  - jal: any `funct3`.
- States (outputs not listed are 0):
  - FETCH: `adr_src` = 0, A = PC, B = 4, ADD, `result_src` = 10. `ir_write` = `pc_write` = `mem_ready`. Stay while `mem_ready` = 0; go to DECODE on `mem_ready` = 1.
  - DECODE: A = OldPC, B = Imm, ADD. Go to MEMADR (lw/sw), EXECUTER, EXECUTEI, JAL, BEQ, or TRAP.
  - MEMADR: A = rs1, B = Imm, ADD. Go to MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: `adr_src` = 1, `result_src` = 00. Stay until `mem_ready`, then MEMWB.
  - MEMWB: `result_src` = 01, `reg_write` = 1, `instr_done` = 1. Go to FETCH.
  - MEMWRITE: `adr_src` = 1, `mem_write` = 1 held until `mem_ready`, `instr_done` when `mem_ready`. Go to FETCH.
  - EXECUTER: A = rs1, B = rs2, `alu_op` = 10. Go to ALUWB.
  - EXECUTEI: A = rs1, B = Imm, `alu_op` = 10. Go to ALUWB.
  - JAL: A = OldPC, B = 4, ADD, `result_src` = 00, `pc_write` = 1. Go to ALUWB.
  - ALUWB: `result_src` = 00, `reg_write` = 1, `instr_done` = 1. Go to FETCH.
  - BEQ: A = rs1, B = rs2, SUB, `result_src` = 00, `pc_write` = `zero`, `instr_done` = 1. Go to FETCH.
  - TRAP: `illegal_instr` = 1; absorbing until reset.
- Memory wait timeout:
  - A wait counter resets on entry to each memory state (FETCH, MEMREAD, MEMWRITE).
  - If `MEM_WAIT_MAX` > 0 and the counter reaches `MEM_WAIT_MAX` with `mem_ready` still 0, go to TRAP.
- Latency with `mem_ready` tied to 1: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.
- Output stability: no strobe may glitch high for one cycle on a state transition.

Optional Feature:
- Macro: `RISCV_MC_BNE_EN`.
- Defined: beq-opcode `funct3` = 001 (bne) is legal and uses the BEQ state with `pc_write` = ~`zero`.
- Undefined: `funct3` = 001 on the branch opcode goes to TRAP.

Test Plan:
- `reset` high 2 cycles, then `op` = 0110011, `funct3` = 000, `funct7b5` = 1, `mem_ready` = 1 → states FETCH, DECODE, EXECUTER, ALUWB. `alu_cntrl` = 001 in EXECUTER; `reg_write` = 1 only in cycle 4; `instr_done` pulses once.
- lw (`op` = 0000011, `funct3` = 010) with `mem_ready` low for 3 cycles in MEMREAD → `adr_src` = 1 held 4 cycles; MEMWB follows with `result_src` = 01, `reg_write` = 1; total 8 cycles.
- beq with `zero` = 1, then with `zero` = 0 → `pc_write` = 1 in BEQ cycle (`alu_cntrl` = 001, `imm_src` = 10), then `pc_write` = 0; both return to FETCH after 3 cycles.
- sw (`op` = 0100011) with `mem_ready` = 0 for 5 cycles → `mem_write` = 1 for 6 consecutive cycles, `imm_src` = 01, no `reg_write`.
- `op` = 0010011, `funct3` = 100 (xori) → TRAP after DECODE, `illegal_instr` = 1 and held 10 cycles; `reset` pulse → back to FETCH, `illegal_instr` = 0.
- jal (`op` = 1101111) → JAL state: `pc_write` = 1, A = 01, B = 10; ALUWB `reg_write` = 1. `MEM_WAIT_MAX` = 4 with `mem_ready` = 0 in FETCH → TRAP on 5th cycle.

Source files
------------

// File: rtl/riscv_mc_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface riscv_mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] imm_src;
    logic [2:0] alu_cntrl;
    logic       illegal_instr;
    logic       instr_done;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write,
        output result_src, alu_src_a, alu_src_b,
        output reg_write, imm_src, alu_cntrl,
        output illegal_instr, instr_done
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write,
        input  result_src, alu_src_a, alu_src_b,
        input  reg_write, imm_src, alu_cntrl,
        input  illegal_instr, instr_done
    );
endinterface

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32 subset control FSM with memory-wait timeout and trap.
// Define RISCV_MC_BNE_EN to accept bne on the branch opcode.
module riscv_mc_controller #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic clk,
    input  logic reset,
    riscv_mc_controller_if.master bus
);
    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
        S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_JAL, S_ALUWB, S_BEQ, S_TRAP
    } state_t;

    state_t state_q, state_n;
    logic [CW-1:0] cnt_q;

    logic is_lw, is_sw, is_r, is_i, is_br, is_jal;
    logic f3_alu, mem_ok, r_ok, i_ok, br_ok;
    logic br_take, wait_to;
    logic [1:0] alu_op;

    assign is_lw  = bus.op == 7'b0000011;
    assign is_sw  = bus.op == 7'b0100011;
    assign is_r   = bus.op == 7'b0110011;
    assign is_i   = bus.op == 7'b0010011;
    assign is_br  = bus.op == 7'b1100011;
    assign is_jal = bus.op == 7'b1101111;

    assign f3_alu = bus.funct3 inside {3'b000, 3'b110, 3'b111};
    assign mem_ok = (is_lw | is_sw) && bus.funct3 == 3'b010;
    assign r_ok   = is_r && f3_alu
                  && (!bus.funct7b5 || bus.funct3 == 3'b000);
    assign i_ok   = is_i && f3_alu;

`ifdef RISCV_MC_BNE_EN
    assign br_ok   = is_br && bus.funct3[2:1] == 2'b00;
    assign br_take = bus.funct3[0] ? !bus.zero : bus.zero;
`else
    assign br_ok   = is_br && bus.funct3 == 3'b000;
    assign br_take = bus.zero;
`endif

    // Counter holds cycles already spent in the current memory state
    assign wait_to = (MEM_WAIT_MAX > 0) && !bus.mem_ready
                  && (cnt_q == CW'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            if (state_n != state_q)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (bus.mem_ready)  state_n = S_DECODE;
                else if (wait_to)   state_n = S_TRAP;
            end
            S_DECODE: begin
                unique case (1'b1)
                    mem_ok:  state_n = S_MEMADR;
                    r_ok:    state_n = S_EXECR;
                    i_ok:    state_n = S_EXECI;
                    is_jal:  state_n = S_JAL;
                    br_ok:   state_n = S_BEQ;
                    default: state_n = S_TRAP;
                endcase
            end
            S_MEMADR:
                state_n = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (bus.mem_ready)  state_n = S_MEMWB;
                else if (wait_to)   state_n = S_TRAP;
            end
            S_MEMWRITE: begin
                if (bus.mem_ready)  state_n = S_FETCH;
                else if (wait_to)   state_n = S_TRAP;
            end
            S_MEMWB:  state_n = S_FETCH;
            S_EXECR:  state_n = S_ALUWB;
            S_EXECI:  state_n = S_ALUWB;
            S_JAL:    state_n = S_ALUWB;
            S_ALUWB:  state_n = S_FETCH;
            S_BEQ:    state_n = S_FETCH;
            S_TRAP:   state_n = S_TRAP;
            default:  state_n = S_FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.adr_src       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.result_src    = 2'b00;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.reg_write     = 1'b0;
        bus.imm_src       = 2'b00;
        bus.alu_cntrl     = 3'b000;
        bus.illegal_instr = 1'b0;
        bus.instr_done    = 1'b0;
        alu_op            = 2'b00;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    bus.alu_src_b  = 2'b10;
                    bus.result_src = 2'b10;
                    bus.ir_write   = bus.mem_ready;
                    bus.pc_write   = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 2'b01;
                end
                S_MEMREAD:
                    bus.adr_src = 1'b1;
                S_MEMWB: begin
                    bus.result_src = 2'b01;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.adr_src    = 1'b1;
                    bus.mem_write  = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_EXECR: begin
                    bus.alu_src_a = 2'b10;
                    alu_op        = 2'b10;
                end
                S_EXECI: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 2'b01;
                    alu_op        = 2'b10;
                end
                S_JAL: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b10;
                    bus.pc_write  = 1'b1;
                end
                S_ALUWB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BEQ: begin
                    bus.alu_src_a  = 2'b10;
                    alu_op         = 2'b01;
                    bus.pc_write   = br_take;
                    bus.instr_done = 1'b1;
                end
                S_TRAP:
                    bus.illegal_instr = 1'b1;
                default: ;
            endcase

            unique case (1'b1)
                is_sw:  bus.imm_src = 2'b01;
                is_br:  bus.imm_src = 2'b10;
                is_jal: bus.imm_src = 2'b11;
                default: bus.imm_src = 2'b00;
            endcase

            case (alu_op)
                2'b01: bus.alu_cntrl = 3'b001;
                2'b10: begin
                    case (bus.funct3)
                        3'b000: bus.alu_cntrl =
                            (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
                        3'b110: bus.alu_cntrl = 3'b110;
                        3'b111: bus.alu_cntrl = 3'b100;
                        default: bus.alu_cntrl = 3'b000;
                    endcase
                end
                default: bus.alu_cntrl = 3'b000;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_mc_controller.sv
// Random + directed bench for riscv_mc_controller.
// A per-instruction reference builds the expected cycle trace.
module tb_riscv_mc_controller;
    localparam int MAXW = 8;
    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b100;
    localparam logic [2:0] OR  = 3'b110;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    riscv_mc_controller_if bus();

    riscv_mc_controller #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic        rst, rdy, z;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [17:0] out;
        string       tag;
    } cyc_t;

    cyc_t q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [6:0] cop;
    logic [2:0] cf3;
    logic       cf7;
    logic [15:0] f_wait, f_go, dec_c, madr, mrd, mwb;
    logic [15:0] mwr_w, mwr_d, jal_c, aluwb, trap_c;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    function automatic logic [15:0] ctl(
        logic pcw, logic adr, logic memw, logic irw,
        logic [1:0] res, logic [1:0] a, logic [1:0] b,
        logic regw, logic [2:0] alu, logic ill, logic done);
        return {pcw, adr, memw, irw, res, a, b, regw, alu, ill, done};
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] op);
        case (op)
            7'h23:   return 2'b01;
            7'h63:   return 2'b10;
            7'h6f:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic legal(logic [6:0] op, logic [2:0] f3,
                                   logic f7);
        logic f3a;
        f3a = (f3 == 3'd0) || (f3 == 3'd6) || (f3 == 3'd7);
        case (op)
            7'h03, 7'h23: return f3 == 3'b010;
            7'h33:        return f3a && (!f7 || f3 == 3'd0);
            7'h13:        return f3a;
`ifdef RISCV_MC_BNE_EN
            7'h63:        return f3 <= 3'd1;
`else
            7'h63:        return f3 == 3'd0;
`endif
            7'h6f:        return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(logic [6:0] op,
                                          logic [2:0] f3, logic f7);
        case (f3)
            3'd0:    return (op[5] && f7) ? SUB : ADD;
            3'd6:    return OR;
            3'd7:    return AND;
            default: return ADD;
        endcase
    endfunction

    task automatic push(string tag, logic rst, logic rdy, logic z,
                        logic [15:0] c);
        cyc_t e;
        e.rst = rst;
        e.rdy = rdy;
        e.z   = z;
        e.op  = cop;
        e.f3  = cf3;
        e.f7  = cf7;
        e.tag = tag;
        e.out = rst ? 18'd0 : {c[15:5], imm_of(cop), c[4:0]};
        q.push_back(e);
    endtask

    // w busy cycles then completion; w >= MAXW means it never completes
    task automatic mem_phase(string tag, int w, logic [15:0] busy,
                             logic [15:0] fin, output bit to);
        int n;
        n = (w >= MAXW) ? MAXW : w;
        for (int i = 0; i < n; i++) push(tag, 0, 0, rb(), busy);
        to = (w >= MAXW);
        if (!to) push(tag, 0, 1, rb(), fin);
    endtask

    task automatic trap_seq(int hold);
        for (int i = 0; i < hold; i++)
            push("trap", 0, rb(), rb(), trap_c);
        push("trap_rst", 1, rb(), rb(), 16'd0);
    endtask

    task automatic instr(logic [6:0] op, logic [2:0] f3, logic f7,
                         int wf, int wm, logic z, int hold);
        bit to;
        logic [2:0] alu;
        logic take;
        cop = op;
        cf3 = f3;
        cf7 = f7;
        mem_phase("fetch", wf, f_wait, f_go, to);
        if (to) begin
            trap_seq(hold);
            return;
        end
        push("decode", 0, rb(), rb(), dec_c);
        if (!legal(op, f3, f7)) begin
            trap_seq(hold);
            return;
        end
        alu = alu_of(op, f3, f7);
        case (op)
            7'h03: begin
                push("memadr", 0, rb(), rb(), madr);
                mem_phase("memread", wm, mrd, mrd, to);
                if (to) trap_seq(hold);
                else push("memwb", 0, rb(), rb(), mwb);
            end
            7'h23: begin
                push("memadr", 0, rb(), rb(), madr);
                mem_phase("memwrite", wm, mwr_w, mwr_d, to);
                if (to) trap_seq(hold);
            end
            7'h33: begin
                push("execr", 0, rb(), rb(),
                     ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, alu, 0, 0));
                push("aluwb", 0, rb(), rb(), aluwb);
            end
            7'h13: begin
                push("execi", 0, rb(), rb(),
                     ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, alu, 0, 0));
                push("aluwb", 0, rb(), rb(), aluwb);
            end
            7'h6f: begin
                push("jal", 0, rb(), rb(), jal_c);
                push("aluwb", 0, rb(), rb(), aluwb);
            end
            default: begin
`ifdef RISCV_MC_BNE_EN
                take = f3[0] ? ~z : z;
`else
                take = z;
`endif
                push("beq", 0, rb(), z,
                     ctl(take, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, SUB, 0, 1));
            end
        endcase
    endtask

    task automatic drive();
        int idx;
        cyc_t e;
        logic [17:0] obs;
        idx = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            reset         = e.rst;
            bus.mem_ready = e.rdy;
            bus.zero      = e.z;
            bus.op        = e.op;
            bus.funct3    = e.f3;
            bus.funct7b5  = e.f7;
            #1;
            obs = {bus.pc_write, bus.adr_src, bus.mem_write,
                   bus.ir_write, bus.result_src, bus.alu_src_a,
                   bus.alu_src_b, bus.reg_write, bus.imm_src,
                   bus.alu_cntrl, bus.illegal_instr, bus.instr_done};
            check($sformatf("%s@%0d", e.tag, idx), 32'(obs), 32'(e.out));
            idx++;
        end
    endtask

    task automatic rand_instr();
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [6:0] ops [8];
        int wf, wm;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h37, 7'h00};
        f7 = rb();
        if ($urandom % 5 == 0) begin
            op = ops[$urandom % 8];
            f3 = 3'($urandom);
        end else begin
            case ($urandom % 11)
                0: begin op = 7'h03; f3 = 3'd2; end
                1: begin op = 7'h23; f3 = 3'd2; end
                2: begin op = 7'h33; f3 = 3'd0; end
                3: begin op = 7'h33; f3 = 3'd0; f7 = 1'b1; end
                4: begin op = 7'h33; f3 = 3'd7; f7 = 1'b0; end
                5: begin op = 7'h33; f3 = 3'd6; f7 = 1'b0; end
                6: begin op = 7'h13; f3 = 3'd0; end
                7: begin op = 7'h13; f3 = 3'd7; end
                8: begin op = 7'h13; f3 = 3'd6; end
                9: begin op = 7'h63; f3 = 3'd0; end
                default: begin op = 7'h6f; f3 = 3'($urandom); end
            endcase
        end
        wf = ($urandom % 20 == 0) ? MAXW : $urandom_range(0, 3);
        wm = ($urandom % 15 == 0) ? MAXW : $urandom_range(0, 4);
        instr(op, f3, f7, wf, wm, rb(), $urandom_range(1, 4));
    endtask

    initial begin
        bus.op        = '0;
        bus.funct3    = '0;
        bus.funct7b5  = 1'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        f_wait = ctl(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, ADD, 0, 0);
        f_go   = ctl(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, ADD, 0, 0);
        dec_c  = ctl(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, ADD, 0, 0);
        madr   = ctl(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, ADD, 0, 0);
        mrd    = ctl(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, ADD, 0, 0);
        mwb    = ctl(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, ADD, 0, 1);
        mwr_w  = ctl(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, ADD, 0, 0);
        mwr_d  = ctl(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, ADD, 0, 1);
        jal_c  = ctl(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, ADD, 0, 0);
        aluwb  = ctl(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, ADD, 0, 1);
        trap_c = ctl(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, ADD, 1, 0);
        cop = 7'h33;
        cf3 = 3'd0;
        cf7 = 1'b1;
        push("reset", 1, 1, 0, 16'd0);
        push("reset", 1, 1, 0, 16'd0);

        instr(7'h33, 3'd0, 1'b1, 0, 0, 1'b0, 1);
        instr(7'h03, 3'd2, 1'b0, 0, 3, 1'b0, 1);
        instr(7'h63, 3'd0, 1'b0, 0, 0, 1'b1, 1);
        instr(7'h63, 3'd0, 1'b0, 0, 0, 1'b0, 1);
        instr(7'h23, 3'd2, 1'b0, 0, 5, 1'b0, 1);
        instr(7'h13, 3'd4, 1'b0, 0, 0, 1'b0, 10);
        instr(7'h6f, 3'd0, 1'b0, 0, 0, 1'b0, 1);
        instr(7'h33, 3'd0, 1'b0, MAXW, 0, 1'b0, 4);
        instr(7'h03, 3'd2, 1'b0, 0, MAXW, 1'b0, 3);
        instr(7'h23, 3'd2, 1'b0, 1, MAXW, 1'b0, 3);
        instr(7'h03, 3'd2, 1'b0, MAXW - 1, MAXW - 1, 1'b0, 1);
        instr(7'h63, 3'd1, 1'b0, 0, 0, 1'b0, 3);
        instr(7'h33, 3'd6, 1'b1, 0, 0, 1'b0, 2);
        instr(7'h13, 3'd6, 1'b1, 2, 0, 1'b0, 1);
        instr(7'h33, 3'd7, 1'b0, 0, 0, 1'b0, 1);
        for (int i = 0; i < 200; i++) rand_instr();
        drive();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
